button_input: RTL and testbench
===============================

Name: button_input

Overview:
- Memory-mapped input peripheral on the same bus as the 7-segment display driver; covers the user-input direction.
- Takes NINPUTS asynchronous switch/button lines, synchronizes and debounces each, and exposes debounced state, raw synchronized state, latched rising-edge events (write-1-to-clear) and an interrupt mask.
- Drives a level interrupt to the CPU when any unmasked edge event is pending.

Parameters:
- NINPUTS, 8, number of input lines (1..32).
- BASE, 32'h20, bus word address of register 0.
- DEBOUNCE_BITS, 16, debounce counter width; MAX = 2^DEBOUNCE_BITS - 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  bus access strobe.
- rw  in  1  1 = write, 0 = read.
- addr  in  32  bus word address.
- data_in  in  32  write data.
- data_out  out  32  registered read data.
- irq  out  1  level interrupt, active high.
- inputs  in  NINPUTS  asynchronous external lines, active high.

Behaviour:
- Reset (clk edge with reset_n=0): sync stages, stable, counters, edge, mask, data_out all 0; irq 0. Reset mid-debounce discards count. Lines held high through reset produce a rising edge event after debounce.
- in_range = addr >= BASE && addr < BASE+4. Offsets:
  - 0 = stable (RO)
  - 1 = edge (R/W1C)
  - 2 = sync (RO)
  - 3 = mask (RW)
- Read data is zero-extended above NINPUTS.
- Synchronizer: two flops per line; sync = second stage. Input change appears in sync 2 clocks later.
- Debounce, per bit, each clk:
  - sync == stable: counter <= 0.
  - sync != stable and counter < MAX: counter++.
  - sync != stable and counter == MAX: stable <= sync, counter <= 0.
  - Net effect: stable flips after MAX+1 consecutive differing cycles. Any agreeing cycle restarts the count.
- Edge capture: rise = stable_next & ~stable, i.e. set on the cycle stable goes 0->1. Falling edges are not captured.
  - Write to offset 1: edge <= (edge & ~data_in) | rise. Set wins over clear for the same bit in the same cycle.
  - Reads never clear.
- Mask: write to offset 3 loads data_in[NINPUTS-1:0].
- Writes to offsets 0, 2 and out-of-range writes are ignored. data_in bits >= NINPUTS are ignored.
- irq = |(edge & mask), combinational from registers. Deasserts the cycle after the clearing write or mask write takes effect.
- Read timing:
  - enable && !rw && in_range at edge N: data_out valid after edge N, i.e. 1-cycle latency. Returns register values before any update made at edge N.
  - Any other cycle (no access, write, out of range): data_out <= 0.
- Back-to-back reads are supported every cycle with no stalls.

Test Plan:
- Reset with inputs=0, DEBOUNCE_BITS=3 (MAX=7) -> data_out=0, irq=0; reads of offsets 0..3 all return 0.
- Raise inputs[0] and hold -> sync bit0 =1 after 2 clk; stable bit0 =1 exactly 8 clk later; offset 1 reads 0x1. Set mask=0x1 -> irq=1 on the cycle after the mask write.
- Glitch: inputs[2] high for 5 clk then low -> offset 0 stays 0x0 and edge stays 0. Then high for 7 sync cycles, low 1, high again -> count restarts; flip occurs only 8 cycles after the final rise.
- W1C race: write 0x1 to offset 1 on the same edge bit0 rises again -> edge bit0 remains 1. Write 0x1 with no rise -> edge=0, irq=0 next cycle.
- Bus decode: write 0xFF to offsets 0 and 2 and to BASE+4 -> no register changes. Read BASE-1 -> data_out=0. Read offset 3 after writing 0x1A5 with NINPUTS=8 -> returns 0xA5.
- Reset mid-debounce at count 5, inputs still high -> after reset, stable=0, then flips after a full 2+8 cycles. Edge bit sets and irq stays 0 because mask was reset to 0.

Source files
------------

// File: rtl/button_input_if.sv
// Bus port bundle for the button_input peripheral: access strobe, address/data and level interrupt.
// Handshake: a transfer happens on every clk edge where enable=1 (no stall, no ready); reads return data_out one cycle later.
interface button_input_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    modport master (output enable, output rw, output addr, output data_in,
                    input  data_out, input irq);
    modport slave  (input  enable, input  rw, input  addr, input  data_in,
                    output data_out, output irq);
endinterface

// File: rtl/button_input.sv
// Memory-mapped button/switch input block: 2-flop sync, per-line debounce, latched rising edges (W1C),
// interrupt mask and a level irq when any unmasked edge is pending.
module button_input #(
    parameter int unsigned NINPUTS       = 8,
    parameter logic [31:0] BASE          = 32'h20,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    button_input_if.slave      bus,
    input  logic [NINPUTS-1:0] inputs
);
    localparam logic [DEBOUNCE_BITS-1:0] MAX      = '1;
    localparam logic [31:0]              END_ADDR = BASE + 32'd4;

    logic [NINPUTS-1:0]       r_sync1;
    logic [NINPUTS-1:0]       r_sync2;
    logic [NINPUTS-1:0]       r_stable;
    logic [NINPUTS-1:0]       r_edge;
    logic [NINPUTS-1:0]       r_mask;
    logic [DEBOUNCE_BITS-1:0] r_cnt [NINPUTS];
    logic [31:0]              r_data_out;

    logic [DEBOUNCE_BITS-1:0] w_cnt_next [NINPUTS];
    logic [NINPUTS-1:0]       w_stable_next;
    logic [NINPUTS-1:0]       w_rise;
    logic [NINPUTS-1:0]       w_wdata;
    logic [31:0]              w_rd_data;
    logic [1:0]               w_offset;
    logic                     w_in_range;
    logic                     w_wr;
    logic                     w_rd;
    logic                     w_unused_data;

    assign w_in_range    = (bus.addr >= BASE) && (bus.addr < END_ADDR);
    assign w_offset      = bus.addr[1:0] - BASE[1:0];
    assign w_wr          = bus.enable && bus.rw && w_in_range;
    assign w_rd          = bus.enable && !bus.rw && w_in_range;
    assign w_wdata       = bus.data_in[NINPUTS-1:0];
    // Upper data_in bits are ignored by design.
    assign w_unused_data = ^bus.data_in;

    // Any agreeing cycle restarts the count; stable flips after MAX+1 consecutive differing cycles.
    always_comb begin
        for (int i = 0; i < int'(NINPUTS); i++) begin
            w_stable_next[i] = r_stable[i];
            w_cnt_next[i]    = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == MAX) w_stable_next[i] = r_sync2[i];
                else                 w_cnt_next[i]    = r_cnt[i] + DEBOUNCE_BITS'(1);
            end
        end
    end

    assign w_rise = w_stable_next & ~r_stable;

    always_comb begin
        w_rd_data = '0;
        case (w_offset)
            2'd0:    w_rd_data[NINPUTS-1:0] = r_stable;
            2'd1:    w_rd_data[NINPUTS-1:0] = r_edge;
            2'd2:    w_rd_data[NINPUTS-1:0] = r_sync2;
            default: w_rd_data[NINPUTS-1:0] = r_mask;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_data_out <= '0;
            for (int i = 0; i < int'(NINPUTS); i++) r_cnt[i] <= '0;
        end else begin
            r_sync1  <= inputs;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            for (int i = 0; i < int'(NINPUTS); i++) r_cnt[i] <= w_cnt_next[i];
            // A rise in the same cycle as a clearing write keeps the bit set.
            if (w_wr && w_offset == 2'd1) r_edge <= (r_edge & ~w_wdata) | w_rise;
            else                          r_edge <= r_edge | w_rise;
            if (w_wr && w_offset == 2'd3) r_mask <= w_wdata;
            r_data_out <= w_rd ? w_rd_data : 32'd0;
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.irq      = |(r_edge & r_mask);
endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with a 3-bit debounce counter (MAX=7): vector tables for bus
// decode plus cycle-exact sequences for sync latency, glitch rejection, W1C race and mid-debounce reset.
module tb_button_input;
    localparam int          NINPUTS = 8;
    localparam logic [31:0] BASE    = 32'h20;
    localparam int          DB      = 3;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    logic               clk;
    logic               reset_n;
    logic [NINPUTS-1:0] inputs;
    int                 total;
    int                 bad;
    vec_t               reset_vecs[$];
    vec_t               decode_vecs[$];
    logic [31:0]        rd;

    button_input_if bus_if ();

    button_input #(.NINPUTS(NINPUTS), .BASE(BASE), .DEBOUNCE_BITS(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .inputs  (inputs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // All drive happens at a negedge; one call consumes exactly one clock.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.enable = 1'b1;
        bus_if.rw     = 1'b0;
        bus_if.addr   = a;
        @(negedge clk);
        d             = bus_if.data_out;
        bus_if.enable = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.enable  = 1'b1;
        bus_if.rw      = 1'b1;
        bus_if.addr    = a;
        bus_if.data_in = d;
        @(negedge clk);
        bus_if.enable  = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        bus_if.enable  = 1'b1;
        bus_if.rw      = v.rw;
        bus_if.addr    = v.addr;
        bus_if.data_in = v.wdata;
        @(negedge clk);
        bus_if.enable  = 1'b0;
        check($sformatf("%s%0d_data", tag, idx), bus_if.data_out, v.exp_data);
        check($sformatf("%s%0d_irq", tag, idx), {31'd0, bus_if.irq}, {31'd0, v.exp_irq});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        inputs         = '0;
        bus_if.enable  = 1'b0;
        bus_if.rw      = 1'b0;
        bus_if.addr    = '0;
        bus_if.data_in = '0;

        reset_vecs.push_back(vec_t'{1'b0, BASE + 32'd0, 32'h0, 32'h0, 1'b0});
        reset_vecs.push_back(vec_t'{1'b0, BASE + 32'd1, 32'h0, 32'h0, 1'b0});
        reset_vecs.push_back(vec_t'{1'b0, BASE + 32'd2, 32'h0, 32'h0, 1'b0});
        reset_vecs.push_back(vec_t'{1'b0, BASE + 32'd3, 32'h0, 32'h0, 1'b0});

        // State entering decode: inputs=0x05, stable=0x05, sync=0x05, edge=0x04, mask=0x01.
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd0, 32'hFF, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd2, 32'hFF, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd4, 32'hFF, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd7, 32'hFF, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b1, BASE - 32'd1, 32'hFF, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd0, 32'h0, 32'h05, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd1, 32'h0, 32'h04, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd2, 32'h0, 32'h05, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd3, 32'h0, 32'h01, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE - 32'd1, 32'h0, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd4, 32'h0, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd3, 32'h1A5, 32'h0, 1'b1});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd3, 32'h0, 32'hA5, 1'b1});
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd1, 32'hFFFFFFFB, 32'h0, 1'b1});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd1, 32'h0, 32'h04, 1'b1});
        decode_vecs.push_back(vec_t'{1'b1, BASE + 32'd3, 32'h0, 32'h0, 1'b0});
        decode_vecs.push_back(vec_t'{1'b0, BASE + 32'd3, 32'h0, 32'h0, 1'b0});

        // Reset
        idle(3);
        check("rst_data_out", bus_if.data_out, 32'h0);
        check("rst_irq", {31'd0, bus_if.irq}, 32'h0);
        reset_n = 1'b1;
        foreach (reset_vecs[i]) run_vec("rst_vec", i, reset_vecs[i]);

        // Rising line 0: sync visible on the read at edge 3, stable on the read at edge 11
        inputs[0] = 1'b1;
        for (int k = 1; k <= 3; k++)
            read_chk($sformatf("rise_sync_k%0d", k), BASE + 32'd2, (k >= 3) ? 32'h1 : 32'h0);
        for (int k = 4; k <= 12; k++)
            read_chk($sformatf("rise_stable_k%0d", k), BASE + 32'd0, (k >= 11) ? 32'h1 : 32'h0);
        read_chk("rise_edge", BASE + 32'd1, 32'h1);
        check("rise_irq_masked", {31'd0, bus_if.irq}, 32'h0);
        bus_write(BASE + 32'd3, 32'h1);
        check("rise_irq_after_mask", {31'd0, bus_if.irq}, 32'h1);

        // Glitch of 5 cycles on line 2 must be rejected
        for (int k = 1; k <= 12; k++) begin
            inputs[2] = (k <= 5);
            read_chk($sformatf("glitch_stable_k%0d", k), BASE + 32'd0, 32'h1);
        end
        read_chk("glitch_edge", BASE + 32'd1, 32'h1);

        // High 7, low 1, high: one cycle short, then a full restart
        for (int k = 1; k <= 20; k++) begin
            inputs[2] = (k <= 7) || (k >= 9);
            read_chk($sformatf("restart_stable_k%0d", k), BASE + 32'd0, (k >= 19) ? 32'h5 : 32'h1);
        end
        read_chk("restart_edge", BASE + 32'd1, 32'h5);

        // Falling edge is not latched; then clear line 0 on the very edge it rises again
        inputs[0] = 1'b0;
        idle(12);
        read_chk("fall_stable", BASE + 32'd0, 32'h4);
        inputs[0] = 1'b1;
        idle(9);
        bus_write(BASE + 32'd1, 32'h1);
        read_chk("race_edge", BASE + 32'd1, 32'h5);
        check("race_irq", {31'd0, bus_if.irq}, 32'h1);
        bus_write(BASE + 32'd1, 32'h1);
        check("w1c_irq", {31'd0, bus_if.irq}, 32'h0);
        read_chk("w1c_edge", BASE + 32'd1, 32'h4);
        read_chk("w1c_stable", BASE + 32'd0, 32'h5);

        // Bus decode table
        foreach (decode_vecs[i]) run_vec("dec_vec", i, decode_vecs[i]);

        // Reset at debounce count 5 on line 1, lines kept high through reset
        inputs = 8'h07;
        idle(7);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_data_out", bus_if.data_out, 32'h0);
        check("mid_rst_irq", {31'd0, bus_if.irq}, 32'h0);
        for (int k = 9; k <= 20; k++)
            read_chk($sformatf("mid_rst_stable_k%0d", k), BASE + 32'd0, (k >= 19) ? 32'h7 : 32'h0);
        read_chk("mid_rst_edge", BASE + 32'd1, 32'h7);
        check("mid_rst_irq_masked", {31'd0, bus_if.irq}, 32'h0);
        read_chk("mid_rst_mask", BASE + 32'd3, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
